// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative MIPS32 multiply/divide sequencer owning the HI/LO pair
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mul0_div1_sel,
  input  logic             is_signed,
  input  logic             kill,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             hilo_rd,
  input  logic             hi0_lo1_sel,
  output logic [WIDTH-1:0] hilo_out,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  // Architectural HI/LO pair
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  // Working registers shared by both loops:
  //  multiply: r_acc_hi = running upper product, r_acc_lo = multiplier shifting out / product low bits,
  //            r_opb = multiplicand
  //  divide:   r_acc_hi = partial remainder, r_acc_lo = dividend shifting out / quotient shifting in,
  //            r_opb = divisor
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic [WIDTH-1:0] r_opb;
  logic [CW-1:0]    r_count;
  logic             r_div;
  logic             r_sign_a;
  logic             r_sign_b;
  logic             r_done;

  logic             w_accept;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;

  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_rem_shift;
  logic [WIDTH:0]   w_rem_diff;
  logic             w_rem_ge;

  logic             w_neg_res;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  // A start is taken only from IDLE and only when no kill accompanies it
  assign w_accept = (r_state == S_IDLE) && start && !kill;

  // Signed operands enter the loops as magnitudes; 0x80000000 maps onto itself, which is the right magnitude
  assign w_mag_a = (is_signed && srca[WIDTH-1]) ? (~srca + 1'b1) : srca;
  assign w_mag_b = (is_signed && srcb[WIDTH-1]) ? (~srcb + 1'b1) : srcb;

  // One radix-2 shift-add step: add multiplicand when the multiplier LSB is set, then shift right
  assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opb} : {(WIDTH + 1){1'b0}});

  // One restoring-divide step: bring in the next dividend bit, subtract the divisor if it fits
  assign w_rem_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
  assign w_rem_diff  = w_rem_shift - {1'b0, r_opb};
  assign w_rem_ge    = (w_rem_shift >= {1'b0, r_opb});

  // Sign correction: product and quotient flip on differing signs, remainder follows the dividend
  assign w_neg_res  = r_sign_a ^ r_sign_b;
  assign w_prod     = {r_acc_hi, r_acc_lo};
  assign w_prod_fix = w_neg_res ? (~w_prod + 1'b1) : w_prod;
  assign w_quo_fix  = w_neg_res ? (~r_acc_lo + 1'b1) : r_acc_lo;
  assign w_rem_fix  = r_sign_a ? (~r_acc_hi + 1'b1) : r_acc_hi;

  assign hilo_out = hi0_lo1_sel ? r_lo : r_hi;
  assign done     = r_done;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state selection and busy/stall outputs; kill aborts from any busy state
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    stall  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = S_CALC;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (kill) begin
          w_next = S_IDLE;
        end else if (r_count == LAST_ITER) begin
          w_next = S_FIX;
        end
      end
      S_FIX: begin
        busy   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    stall = busy && (start || hilo_rd);
  end

  // Operand capture, iteration datapath, HI/LO write-back and the done pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_opb    <= '0;
      r_count  <= '0;
      r_div    <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_div    <= mul0_div1_sel;
            r_sign_a <= is_signed & srca[WIDTH-1];
            r_sign_b <= is_signed & srcb[WIDTH-1];
            r_count  <= '0;
            r_acc_hi <= '0;
            if (mul0_div1_sel) begin
              r_acc_lo <= w_mag_a;
              r_opb    <= w_mag_b;
            end else begin
              r_acc_lo <= w_mag_b;
              r_opb    <= w_mag_a;
            end
          end
        end
        S_CALC: begin
          if (!kill) begin
            r_count <= r_count + CW'(1);
            if (r_div) begin
              r_acc_hi <= w_rem_ge ? w_rem_diff[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
              r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_rem_ge};
            end else begin
              r_acc_hi <= w_mul_sum[WIDTH:1];
              r_acc_lo <= {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
            end
          end
        end
        S_FIX: begin
          if (!kill) begin
            if (r_div) begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end else begin
              r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
              r_lo <= w_prod_fix[WIDTH-1:0];
            end
            r_done <= 1'b1;
          end
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mul0_div1_sel;
  logic        is_signed;
  logic        kill;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        hilo_rd;
  logic        hi0_lo1_sel;
  logic [31:0] hilo_out;
  logic        busy;
  logic        stall;
  logic        done;

  int errors = 0;
  int checks = 0;
  int n_busy;
  int n_done;
  int n_stall;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .mul0_div1_sel (mul0_div1_sel),
    .is_signed     (is_signed),
    .kill          (kill),
    .srca          (srca),
    .srcb          (srcb),
    .hilo_rd       (hilo_rd),
    .hi0_lo1_sel   (hi0_lo1_sel),
    .hilo_out      (hilo_out),
    .busy          (busy),
    .stall         (stall),
    .done          (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    hi0_lo1_sel = 1'b0;
    #1;
    chk({tag, " hi"}, hilo_out, exp_hi);
    hi0_lo1_sel = 1'b1;
    #1;
    chk({tag, " lo"}, hilo_out, exp_lo);
  endtask

  // Called at a falling edge; returns at the falling edge of the first cycle after acceptance
  task automatic start_op(input logic div, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic hold);
    mul0_div1_sel = div;
    is_signed     = sgn;
    srca          = a;
    srcb          = b;
    start         = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin
      start = 1'b0;
      srca  = 32'h5A5A1234;
      srcb  = 32'h0F0F0F0F;
    end
  endtask

  // Counts busy cycles; returns at the falling edge of the first non-busy cycle
  task automatic wait_idle();
    n_busy  = 0;
    n_done  = 0;
    n_stall = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      n_busy++;
      if (done) n_done++;
      if (stall) n_stall++;
      @(negedge clk);
    end
  endtask

  task automatic run_and_check(input string tag, input logic div, input logic sgn, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    start_op(div, sgn, a, b, 1'b0);
    wait_idle();
    chk({tag, " busy cycles"}, 32'(n_busy), 32'd33);
    chk({tag, " done while busy"}, 32'(n_done), 32'd0);
    chk({tag, " done pulse"}, 32'(done), 32'd1);
    check_hilo(tag, exp_hi, exp_lo);
    @(negedge clk);
    chk({tag, " done cleared"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    mul0_div1_sel = 1'b0;
    is_signed = 1'b0;
    kill = 1'b0;
    srca = 32'h0;
    srcb = 32'h0;
    hilo_rd = 1'b0;
    hi0_lo1_sel = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset stall", 32'(stall), 32'd0);
    check_hilo("reset", 32'h0, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    run_and_check("mult 7*-3", 1'b0, 1'b1, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);

    // Kill mid-calculation leaves HI/LO untouched and never pulses done
    start_op(1'b0, 1'b1, 32'd2, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    chk("kill pre busy", 32'(busy), 32'd1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill busy", 32'(busy), 32'd0);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) n_done++;
      @(negedge clk);
    end
    chk("kill done count", 32'(n_done), 32'd0);
    check_hilo("kill keep", 32'hFFFFFFFF, 32'hFFFFFFEB);

    // Start together with kill in IDLE is ignored
    start = 1'b1;
    kill = 1'b1;
    @(negedge clk);
    chk("start+kill busy", 32'(busy), 32'd0);
    start = 1'b0;
    kill = 1'b0;

    run_and_check("divu 100/7", 1'b1, 1'b0, 32'd100, 32'd7, 32'h00000002, 32'h0000000E);
    run_and_check("div -7/2", 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_and_check("divu 5/0", 1'b1, 1'b0, 32'd5, 32'd0, 32'h00000005, 32'hFFFFFFFF);
    run_and_check("div min/-1", 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // MULTU max*max, MFLO arrives while busy and must stall until the done cycle
    start_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    #1;
    chk("unrelated no stall", 32'(stall), 32'd0);
    @(negedge clk);
    @(negedge clk);
    hilo_rd = 1'b1;
    hi0_lo1_sel = 1'b1;
    #1;
    wait_idle();
    chk("mflo busy cycles", 32'(n_busy), 32'd31);
    chk("mflo stall cycles", 32'(n_stall), 32'd31);
    chk("mflo done", 32'(done), 32'd1);
    chk("mflo done stall", 32'(stall), 32'd0);
    chk("mflo value", hilo_out, 32'h00000001);
    hi0_lo1_sel = 1'b0;
    #1;
    chk("mfhi value", hilo_out, 32'hFFFFFFFE);
    hilo_rd = 1'b0;
    @(negedge clk);

    // Start held high through busy is accepted again in the done cycle
    start_op(1'b0, 1'b0, 32'd2, 32'd3, 1'b1);
    wait_idle();
    chk("hold busy cycles", 32'(n_busy), 32'd33);
    chk("hold stall cycles", 32'(n_stall), 32'd33);
    chk("hold done", 32'(done), 32'd1);
    chk("hold done stall", 32'(stall), 32'd0);
    check_hilo("hold first", 32'h0, 32'h00000006);
    @(negedge clk);
    chk("b2b accepted", 32'(busy), 32'd1);
    start = 1'b0;
    wait_idle();
    chk("b2b busy cycles", 32'(n_busy), 32'd33);
    chk("b2b done", 32'(done), 32'd1);
    check_hilo("b2b", 32'h0, 32'h00000006);
    @(negedge clk);

    // Reset mid-divide clears everything, then a fresh multiply completes
    start_op(1'b1, 1'b1, 32'd100, 32'd7, 1'b0);
    repeat (14) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset done", 32'(done), 32'd0);
    check_hilo("midreset", 32'h0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    run_and_check("mult 4*5", 1'b0, 1'b1, 32'd4, 32'd5, 32'h00000000, 32'h00000014);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
